// File: rtl/pmci_vdm_sched_pkg.sv
// rtl/pmci_vdm_sched_pkg.sv - shared types, FCR field positions and default CSR addresses for the VDM tx scheduler
package pmci_vdm_sched_pkg;

    localparam int FCR_GO_BIT    = 0;
    localparam int FCR_SOM_BIT   = 1;
    localparam int FCR_EOM_BIT   = 2;
    localparam int FCR_ABORT_BIT = 3;
    localparam int FCR_CNT_LSB   = 8;

    localparam logic [31:0] FCR_ADDR_DEF = 32'h0008_2000;
    localparam logic [31:0] PDR_ADDR_DEF = 32'h0008_2008;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_NO_SOM    = 3'd1,
        ERR_EARLY_SOM = 3'd2,
        ERR_OVERSIZE  = 3'd3,
        ERR_TIMEOUT   = 3'd4
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT,
        ST_WAIT_DONE,
        ST_ABORT,
        ST_DRAIN
    } state_e;

    function automatic logic [31:0] fcr_word(input logic [7:0] cnt, input logic abort,
                                             input logic eom, input logic som, input logic go);
        logic [31:0] w;
        w                   = '0;
        w[FCR_CNT_LSB +: 8] = cnt;
        w[FCR_ABORT_BIT]    = abort;
        w[FCR_EOM_BIT]      = eom;
        w[FCR_SOM_BIT]      = som;
        w[FCR_GO_BIT]       = go;
        return w;
    endfunction

endpackage

// File: rtl/pmci_vdm_rr_arb.sv
// rtl/pmci_vdm_rr_arb.sv - round-robin arbiter searching upward from a pointer, one-hot and index grant
module pmci_vdm_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       gnt_any
);

    localparam int IW = $clog2(NUM_REQ);

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!gnt_any && req[idx]) begin
                gnt_any      = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/pmci_vdm_tx_sched.sv
// rtl/pmci_vdm_tx_sched.sv - PMCI VDM transmit scheduler: grants a requester per MCTP message, writes PDR/FCR
// Optional message/error statistics ports built when PMCI_VDM_SCHED_STATS_EN is defined.
module pmci_vdm_tx_sched
    import pmci_vdm_sched_pkg::*;
#(
    parameter int          NUM_REQ     = 4,
    parameter int          PKT_MAX_DW  = 16,
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [31:0] FCR_ADDR    = FCR_ADDR_DEF,
    parameter logic [31:0] PDR_ADDR    = PDR_ADDR_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*32-1:0]      req_data,
    input  logic [NUM_REQ-1:0]         req_sop,
    input  logic [NUM_REQ-1:0]         req_eop,
    input  logic [NUM_REQ-1:0]         req_som,
    input  logic [NUM_REQ-1:0]         req_eom,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [31:0]                wr_addr,
    output logic [31:0]                wr_data,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_vld,
    output logic                       err_pulse,
    output logic [2:0]                 err_code
`ifdef PMCI_VDM_SCHED_STATS_EN
    ,
    output logic [15:0]                stat_msg_cnt,
    output logic [15:0]                stat_err_cnt
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(PKT_MAX_DW + 1);

    state_e          state_q, state_d;
    err_code_e       err_code_q, err_code_d;
    logic [IW-1:0]   grant_id_q, grant_id_d, rr_q, rr_d, rr_next, arb_idx;
    logic            lock_q, lock_d, som_q, som_d, eom_q, eom_d;
    logic            dabort_q, dabort_d, err_pulse_q, err_pulse_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     tmo_q, tmo_d;
    logic [NUM_REQ-1:0] arb_gnt;
    logic            arb_any, win_som, win_eom;
    logic            cur_valid, cur_sop, cur_eop, cur_som, cur_eom;
    logic [31:0]     cur_data;
    logic            dword_full, accept, ld_rdy, tmo_run, tmo_hit;

    pmci_vdm_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_valid & req_sop),
        .ptr     (rr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign win_som   = |(arb_gnt & req_som);
    assign win_eom   = |(arb_gnt & req_eom);
    assign cur_valid = req_valid[grant_id_q];
    assign cur_sop   = req_sop[grant_id_q];
    assign cur_eop   = req_eop[grant_id_q];
    assign cur_som   = req_som[grant_id_q];
    assign cur_eom   = req_eom[grant_id_q];
    assign cur_data  = req_data[{grant_id_q, 5'b00000} +: 32];
    assign rr_next   = (grant_id_q == IW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    // ABORT is excluded so a stuck FCR write cannot raise back-to-back timeouts.
    assign tmo_run = (state_q == ST_IDLE) ? lock_q : (state_q != ST_ABORT);
    assign tmo_hit = tmo_run && (tmo_q == 16'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        lock_d      = lock_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        som_d       = som_q;
        eom_d       = eom_q;
        dabort_d    = dabort_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        req_ready   = '0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        accept      = 1'b0;
        dword_full  = (cnt_q == CW'(PKT_MAX_DW));
        ld_rdy      = wr_ready & ~dword_full;
        case (state_q)
            ST_IDLE: begin
                if (lock_q) begin
                    if (tmo_hit) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_TIMEOUT;
                        state_d     = ST_ABORT;
                    end else if (cur_valid && cur_sop) begin
                        som_d = cur_som;
                        eom_d = cur_eom;
                        cnt_d = '0;
                        if (cur_som) begin
                            err_pulse_d = 1'b1;
                            err_code_d  = ERR_EARLY_SOM;
                            state_d     = ST_ABORT;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end else if (arb_any) begin
                    grant_id_d = arb_idx;
                    som_d      = win_som;
                    eom_d      = win_eom;
                    cnt_d      = '0;
                    if (!win_som) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_NO_SOM;
                        dabort_d    = 1'b0;
                        state_d     = ST_DRAIN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                req_ready[grant_id_q] = ld_rdy;
                wr_valid = cur_valid & ~dword_full;
                wr_addr  = PDR_ADDR;
                wr_data  = cur_data;
                accept   = cur_valid & ld_rdy;
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cur_eop) begin
                        state_d = ST_COMMIT;
                    end else if (cnt_q == CW'(PKT_MAX_DW - 1)) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_OVERSIZE;
                        dabort_d    = 1'b1;
                        state_d     = ST_DRAIN;
                    end
                end else if (tmo_hit) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = ST_ABORT;
                end
            end
            ST_COMMIT: begin
                wr_valid = 1'b1;
                wr_addr  = FCR_ADDR;
                wr_data  = fcr_word(8'(cnt_q), 1'b0, eom_q, som_q, 1'b1);
                if (wr_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_hit) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = ST_ABORT;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    if (eom_q) begin
                        lock_d = 1'b0;
                        rr_d   = rr_next;
                    end else begin
                        lock_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = ST_ABORT;
                end
            end
            ST_ABORT: begin
                wr_valid = 1'b1;
                wr_addr  = FCR_ADDR;
                wr_data  = fcr_word(8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
                if (wr_ready) begin
                    lock_d  = 1'b0;
                    rr_d    = rr_next;
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                req_ready[grant_id_q] = 1'b1;
                accept = cur_valid;
                if (accept && cur_eop) begin
                    state_d = dabort_q ? ST_ABORT : ST_IDLE;
                end else if (!accept && tmo_hit) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = ST_ABORT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tmo_d = (state_d != state_q || accept || !tmo_run) ? 16'd0 : tmo_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_id_q  <= '0;
            lock_q      <= 1'b0;
            rr_q        <= '0;
            cnt_q       <= '0;
            som_q       <= 1'b0;
            eom_q       <= 1'b0;
            dabort_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            lock_q      <= lock_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            som_q       <= som_d;
            eom_q       <= eom_d;
            dabort_q    <= dabort_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            tmo_q       <= tmo_d;
        end
    end

    assign grant_id  = grant_id_q;
    assign grant_vld = lock_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;

`ifdef PMCI_VDM_SCHED_STATS_EN
    logic [15:0] msg_cnt_q, msg_cnt_d, err_cnt_q, err_cnt_d;
    logic        msg_done;

    assign msg_done = (state_q == ST_WAIT_DONE) && tx_done && eom_q;

    always_comb begin
        msg_cnt_d = msg_cnt_q;
        err_cnt_d = err_cnt_q;
        if (msg_done && msg_cnt_q != 16'hFFFF) msg_cnt_d = msg_cnt_q + 16'd1;
        if (err_pulse_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            msg_cnt_q <= msg_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign stat_msg_cnt = msg_cnt_q;
    assign stat_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_pmci_vdm_tx_sched.sv
// tb/tb_pmci_vdm_tx_sched.sv - self-checking bench: random packet payloads against a message-level write/error model
module tb_pmci_vdm_tx_sched;

    localparam int          NR    = 4;
    localparam int          PMAX  = 16;
    localparam int          TMO   = 1024;
    localparam logic [31:0] FCR   = 32'h0008_2000;
    localparam logic [31:0] PDR   = 32'h0008_2008;
    localparam logic [31:0] ABORT = 32'h0000_0008;
    localparam int M_OK = 0, M_DRAIN = 1, M_OVR = 2, M_NOCMT = 3;

    typedef struct {
        logic [31:0] d;
        logic        sop, eop, som, eom;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0, req_ready, req_sop = '0, req_eop = '0, req_som = '0, req_eom = '0;
    logic [NR*32-1:0]  req_data = '0;
    logic              wr_valid, wr_ready = 1'b0, tx_done = 1'b0;
    logic [31:0]       wr_addr, wr_data;
    logic [1:0]        grant_id;
    logic              grant_vld, err_pulse;
    logic [2:0]        err_code;
`ifdef PMCI_VDM_SCHED_STATS_EN
    logic [15:0]       stat_msg_cnt, stat_err_cnt;
`endif

    beat_t       rq [NR][$];
    logic [63:0] wq[$], exp_wr[$];
    logic [2:0]  eq[$], exp_err[$];
    int          checks = 0, errors = 0, cyc = 0;
    int          done_tmr = 0, last_fcr_cyc = 0, last_pdr_cyc = 0, err_cyc = 0;
    bit          auto_done = 1'b1, hold_fcr = 1'b0, bp = 1'b0, saw_lock = 1'b0;
    logic [NR-1:0] hs;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pmci_vdm_tx_sched u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_sop   (req_sop),
        .req_eop   (req_eop),
        .req_som   (req_som),
        .req_eom   (req_eom),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .tx_done   (tx_done),
        .grant_id  (grant_id),
        .grant_vld (grant_vld),
        .err_pulse (err_pulse),
`ifdef PMCI_VDM_SCHED_STATS_EN
        .stat_msg_cnt (stat_msg_cnt),
        .stat_err_cnt (stat_err_cnt),
`endif
        .err_code  (err_code)
    );

    // Requester/CSR-side agent: observe at negedge, update inputs just after posedge.
    initial forever begin
        @(negedge clk);
        hs = req_valid & req_ready;
        if (wr_valid && wr_ready) begin
            wq.push_back({wr_addr, wr_data});
            if (wr_addr == PDR) last_pdr_cyc = cyc;
            if (wr_addr == FCR && wr_data[0]) begin
                last_fcr_cyc = cyc;
                if (auto_done) done_tmr = 3;
            end
        end
        if (err_pulse) begin
            eq.push_back(err_code);
            err_cyc = cyc;
        end
        if (grant_vld && grant_id == 2'd1) saw_lock = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs[i]) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_data[i*32 +: 32] = rq[i][0].d;
                req_sop[i] = rq[i][0].sop;
                req_eop[i] = rq[i][0].eop;
                req_som[i] = rq[i][0].som;
                req_eom[i] = rq[i][0].eom;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        if (done_tmr > 0) begin
            done_tmr--;
            tx_done = (done_tmr == 0);
        end else begin
            tx_done = 1'b0;
        end
        #1;
        if (hold_fcr && wr_valid && wr_addr == FCR && wr_data[0]) wr_ready = 1'b0;
        else if (bp) wr_ready = ($urandom_range(0, 3) != 0);
        else wr_ready = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fcr_go(input int n, input bit som, input bit eom);
        return (32'(n) << 8) | (32'(eom) << 2) | (32'(som) << 1) | 32'd1;
    endfunction

    // Queue one packet on requester r and record the CSR writes the message rules predict.
    task automatic gen_pkt(input int r, input int n, input bit som, input bit eom, input int mode);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = $urandom; b.sop = (i == 0); b.eop = (i == n - 1); b.som = som; b.eom = eom;
            rq[r].push_back(b);
            if (mode == M_OK || mode == M_NOCMT || (mode == M_OVR && i < PMAX))
                exp_wr.push_back({PDR, b.d});
        end
        if (mode == M_OK) exp_wr.push_back({FCR, fcr_go(n, som, eom)});
    endtask

    function automatic bit busy();
        for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_scen(input string tag);
        int t = 0;
        while ((wq.size() < exp_wr.size() || eq.size() < exp_err.size() || busy()) && t < 4000) begin
            @(posedge clk);
            t++;
        end
        chk({tag, "_in_time"}, 32'(t < 4000), 32'd1);
        repeat (20) @(posedge clk);
        #3;
    endtask

    task automatic check_scen(input string tag);
        wait_scen(tag);
        chk({tag, "_nwr"}, 32'(wq.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wq.size(); i++) begin
            chk($sformatf("%s_wr%0d_addr", tag, i), wq[i][63:32], exp_wr[i][63:32]);
            chk($sformatf("%s_wr%0d_data", tag, i), wq[i][31:0], exp_wr[i][31:0]);
        end
        chk({tag, "_nerr"}, 32'(eq.size()), 32'(exp_err.size()));
        for (int i = 0; i < exp_err.size() && i < eq.size(); i++)
            chk($sformatf("%s_err%0d", tag, i), 32'(eq[i]), 32'(exp_err[i]));
        wq.delete(); exp_wr.delete(); eq.delete(); exp_err.delete();
    endtask

    initial begin
        int n1, n2, n3, d;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_grant_vld", 32'(grant_vld), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_err_pulse", 32'(err_pulse), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #3;

        gen_pkt(0, 4, 1'b1, 1'b1, M_OK);
        check_scen("single");
        chk("single_unlock", 32'(grant_vld), 32'd0);

        bp = 1'b1;
        saw_lock = 1'b0;
        n1 = $urandom_range(1, PMAX); n2 = $urandom_range(1, PMAX); n3 = $urandom_range(1, PMAX);
        gen_pkt(1, n1, 1'b1, 1'b0, M_OK);
        gen_pkt(1, n2, 1'b0, 1'b0, M_OK);
        gen_pkt(1, n3, 1'b0, 1'b1, M_OK);
        gen_pkt(2, $urandom_range(1, PMAX), 1'b1, 1'b1, M_OK);
        check_scen("multi");
        chk("multi_lock_seen", 32'(saw_lock), 32'd1);
        chk("multi_unlock", 32'(grant_vld), 32'd0);
        bp = 1'b0;

        gen_pkt(0, 3, 1'b0, 1'($urandom_range(0, 1)), M_DRAIN);
        exp_err.push_back(3'd1);
        check_scen("nosom");
        chk("nosom_code_held", 32'(err_code), 32'd1);
        chk("nosom_no_lock", 32'(grant_vld), 32'd0);

        n1 = $urandom_range(1, 8); n2 = $urandom_range(1, 8);
        gen_pkt(3, n1, 1'b1, 1'b0, M_OK);
        exp_wr.push_back({FCR, ABORT});
        exp_err.push_back(3'd2);
        gen_pkt(3, n2, 1'b1, 1'b1, M_OK);
        check_scen("early_som");

        gen_pkt(0, PMAX + 1, 1'b1, 1'b1, M_OVR);
        exp_err.push_back(3'd3);
        exp_wr.push_back({FCR, ABORT});
        check_scen("oversize");

        auto_done = 1'b0;
        gen_pkt(1, $urandom_range(1, 8), 1'b1, 1'b1, M_OK);
        exp_wr.push_back({FCR, ABORT});
        exp_err.push_back(3'd4);
        check_scen("tmo_done");
        d = err_cyc - last_fcr_cyc;
        checks++;
        assert (d >= TMO && d <= TMO + 2) else begin
            errors++;
            $error("FAIL tmo_done_delay observed=%0d expected=%0d..%0d", d, TMO, TMO + 2);
        end
        auto_done = 1'b1;

        hold_fcr = 1'b1;
        gen_pkt(2, $urandom_range(1, 8), 1'b1, 1'b1, M_NOCMT);
        exp_wr.push_back({FCR, ABORT});
        exp_err.push_back(3'd4);
        check_scen("tmo_commit");
        d = err_cyc - last_pdr_cyc;
        checks++;
        assert (d >= TMO && d <= TMO + 2) else begin
            errors++;
            $error("FAIL tmo_commit_delay observed=%0d expected=%0d..%0d", d, TMO, TMO + 2);
        end
        hold_fcr = 1'b0;

        bp = 1'b1;
        gen_pkt(3, $urandom_range(1, PMAX), 1'b1, 1'b0, M_OK);
        gen_pkt(3, $urandom_range(1, PMAX), 1'b0, 1'b1, M_OK);
        gen_pkt(0, $urandom_range(1, PMAX), 1'b1, 1'b1, M_OK);
        check_scen("recover");
        chk("recover_code_held", 32'(err_code), 32'd4);
        chk("recover_unlock", 32'(grant_vld), 32'd0);
`ifdef PMCI_VDM_SCHED_STATS_EN
        chk("stat_msg", 32'(stat_msg_cnt), 32'd6);
        chk("stat_err", 32'(stat_err_cnt), 32'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
